// File: rtl/ad_capture_ctrl_if.sv
// rtl/ad_capture_ctrl_if.sv - ADC pin, trigger control and capture RAM signals of ad_capture_ctrl
// master is the capture controller, slave is the surrounding logic (ADC pins, RAM, reader).
interface ad_capture_ctrl_if #(
  parameter int DATA_W     = 10,
  parameter int DEPTH_LOG2 = 10,
  parameter int OTR_W      = 16
) ();
  logic                    start;
  logic                    force_trig;
  logic [DATA_W-1:0]       trig_level;
  logic                    trig_rising;
  logic                    ack;
  logic [DATA_W-1:0]       ad_data1;
  logic [DATA_W-1:0]       ad_data2;
  logic                    OTR1;
  logic                    OTR2;
  logic                    ad1oe;
  logic                    ad2oe;
  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic [2*DATA_W-1:0]     wr_data;
  logic [OTR_W-1:0]        otr1_cnt;
  logic [OTR_W-1:0]        otr2_cnt;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, force_trig, trig_level, trig_rising, ack,
    input  ad_data1, ad_data2, OTR1, OTR2,
    output ad1oe, ad2oe, wr_en, wr_addr, wr_data,
    output otr1_cnt, otr2_cnt, busy, done
  );

  modport slave (
    output start, force_trig, trig_level, trig_rising, ack,
    output ad_data1, ad_data2, OTR1, OTR2,
    input  ad1oe, ad2oe, wr_en, wr_addr, wr_data,
    input  otr1_cnt, otr2_cnt, busy, done
  );
endinterface

// File: rtl/ad_capture_ctrl.sv
// rtl/ad_capture_ctrl.sv - dual-channel ADC capture sequencer (settle, level trigger, block write, OTR count)
// All control outputs decode the state register, so an async reset clears them immediately.
module ad_capture_ctrl #(
  parameter int DATA_W     = 10,
  parameter int DEPTH_LOG2 = 10,
  parameter int SETTLE_CYC = 8,
  parameter int OTR_W      = 16
) (
  input  logic                clk_20M,
  input  logic                rst,
  ad_capture_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR   = '1;
  localparam logic [7:0]            SETTLE_INIT = 8'(SETTLE_CYC);

  state_t                state;
  state_t                state_nx;
  logic [DATA_W-1:0]     s1;
  logic [DATA_W-1:0]     s2;
  logic [DATA_W-1:0]     p1;
  logic                  so1;
  logic                  so2;
  logic [7:0]            settle_cnt;
  logic                  wr_otr1;
  logic                  wr_otr2;
  logic                  level_hit;
  logic                  trig;
  logic [DEPTH_LOG2-1:0] wr_addr_q;
  logic [2*DATA_W-1:0]   wr_data_q;
  logic [OTR_W-1:0]      otr1_q;
  logic [OTR_W-1:0]      otr2_q;

  always_ff @(posedge clk_20M or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      p1  <= '0;
      so1 <= 1'b0;
      so2 <= 1'b0;
    end else begin
      s1  <= bus.ad_data1;
      s2  <= bus.ad_data2;
      p1  <= s1;
      so1 <= bus.OTR1;
      so2 <= bus.OTR2;
    end
  end

  always_comb begin
    level_hit = 1'b0;
    if (bus.trig_rising) begin
      level_hit = (p1 < bus.trig_level) && (s1 >= bus.trig_level);
    end else begin
      level_hit = (p1 > bus.trig_level) && (s1 <= bus.trig_level);
    end
    trig = level_hit | bus.force_trig;
  end

  always_ff @(posedge clk_20M or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.start) state_nx = SETTLE;
      SETTLE:    if (settle_cnt <= 8'd1) state_nx = WAIT_TRIG;
      WAIT_TRIG: if (trig) state_nx = CAPTURE;
      CAPTURE:   if (wr_addr_q == LAST_ADDR) state_nx = DONE;
      DONE:      if (bus.ack) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Write address/data lead the CAPTURE state by one register stage: the
  // pair loaded on the trigger edge is the one presented with addr 0.
  always_ff @(posedge clk_20M or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_otr1    <= 1'b0;
      wr_otr2    <= 1'b0;
      otr1_q     <= '0;
      otr2_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            settle_cnt <= SETTLE_INIT;
            otr1_q     <= '0;
            otr2_q     <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
        end
        WAIT_TRIG: begin
          if (trig) begin
            wr_addr_q <= '0;
            wr_data_q <= {s2, s1};
            wr_otr1   <= so1;
            wr_otr2   <= so2;
          end
        end
        CAPTURE: begin
          if (wr_otr1 && (otr1_q != {OTR_W{1'b1}})) otr1_q <= otr1_q + 1'b1;
          if (wr_otr2 && (otr2_q != {OTR_W{1'b1}})) otr2_q <= otr2_q + 1'b1;
          if (wr_addr_q != LAST_ADDR) begin
            wr_addr_q <= wr_addr_q + 1'b1;
            wr_data_q <= {s2, s1};
            wr_otr1   <= so1;
            wr_otr2   <= so2;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state == SETTLE) || (state == WAIT_TRIG) || (state == CAPTURE);
  assign bus.done     = (state == DONE);
  assign bus.ad1oe    = !bus.busy;
  assign bus.ad2oe    = !bus.busy;
  assign bus.wr_en    = (state == CAPTURE);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.otr1_cnt = otr1_q;
  assign bus.otr2_cnt = otr2_q;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// tb/tb_ad_capture_ctrl.sv - directed-vector bench for ad_capture_ctrl
// Writes are logged per address by a negedge monitor; each test task checks its own results.
module tb_ad_capture_ctrl;
  localparam int DATA_W     = 10;
  localparam int DEPTH_LOG2 = 4;
  localparam int SETTLE_CYC = 8;
  localparam int OTR_W      = 2;

  logic clk_20M = 1'b0;
  logic rst     = 1'b1;
  always #25 clk_20M = ~clk_20M;

  ad_capture_ctrl_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .OTR_W(OTR_W)) bus ();

  ad_capture_ctrl #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .SETTLE_CYC(SETTLE_CYC), .OTR_W(OTR_W)
  ) dut (
    .clk_20M(clk_20M),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int total_wr = 0;
  int seq_err = 0;
  int cyc_last = -1;
  int done_rise_cyc = -1;
  logic prev_wr_en = 1'b0;
  logic prev_done = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [19:0] data_at [16];

  always @(posedge clk_20M) cyc <= cyc + 1;

  always @(negedge clk_20M) begin
    if (bus.wr_en === 1'b1) begin
      data_at[bus.wr_addr] = bus.wr_data;
      total_wr = total_wr + 1;
      if (prev_wr_en ? (bus.wr_addr != prev_addr + 4'd1) : (bus.wr_addr != 4'd0))
        seq_err = seq_err + 1;
      if (bus.wr_addr == 4'd15) cyc_last = cyc;
    end
    if (bus.done === 1'b1 && !prev_done) done_rise_cyc = cyc;
    prev_wr_en = (bus.wr_en === 1'b1);
    prev_addr  = bus.wr_addr;
    prev_done  = (bus.done === 1'b1);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_20M);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if ({bus.ad1oe, bus.ad2oe, bus.wr_en, bus.busy, bus.done} !== 5'b11000) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %b want 11000", {bus.ad1oe, bus.ad2oe, bus.wr_en, bus.busy, bus.done});
    end
    n_vec++;
    if (bus.wr_addr !== 4'd0 || bus.wr_data !== 20'd0) begin
      n_miss++;
      $display("FAIL reset_bus: addr %0d data %h want 0 0", bus.wr_addr, bus.wr_data);
    end
    n_vec++;
    if (bus.otr1_cnt !== 2'd0 || bus.otr2_cnt !== 2'd0) begin
      n_miss++;
      $display("FAIL reset_otr: got %0d %0d want 0 0", bus.otr1_cnt, bus.otr2_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_rising();
    int base_wr;
    int base_seq;
    logic saw_wr;
    base_wr  = total_wr;
    base_seq = seq_err;
    saw_wr   = 1'b0;
    bus.trig_level  = 10'd512;
    bus.trig_rising = 1'b1;
    bus.ad_data1    = '0;
    bus.ad_data2    = '0;
    bus.start       = 1'b1;
    #1;
    n_vec++;
    if (bus.ad1oe !== 1'b1) begin
      n_miss++;
      $display("FAIL rise_oe_idle: ad1oe %b want 1", bus.ad1oe);
    end
    step();
    bus.start = 1'b0;
    n_vec++;
    if ({bus.ad1oe, bus.ad2oe, bus.busy} !== 3'b001) begin
      n_miss++;
      $display("FAIL rise_oe_low: oe1 oe2 busy %b want 001", {bus.ad1oe, bus.ad2oe, bus.busy});
    end
    for (int i = 0; i < 8; i++) begin
      bus.ad_data1 = (i == 3) ? 10'd1000 : 10'd0;
      step();
      if (bus.wr_en === 1'b1) saw_wr = 1'b1;
    end
    for (int i = 0; i < 3; i++) step();
    n_vec++;
    if (saw_wr !== 1'b0 || bus.busy !== 1'b1) begin
      n_miss++;
      $display("FAIL rise_settle: wr seen %b busy %b want 0 1", saw_wr, bus.busy);
    end
    for (int k = 0; k < 40; k++) begin
      bus.ad_data1 = 10'(64 * k);
      bus.ad_data2 = 10'(100 + k);
      step();
    end
    n_vec++;
    if (total_wr - base_wr != 16 || seq_err != base_seq) begin
      n_miss++;
      $display("FAIL rise_count: writes %0d seq_err %0d want 16 0", total_wr - base_wr, seq_err - base_seq);
    end
    n_vec++;
    if (data_at[0] !== {10'd108, 10'd512}) begin
      n_miss++;
      $display("FAIL rise_addr0: got %h want %h", data_at[0], {10'd108, 10'd512});
    end
    n_vec++;
    if (data_at[5] !== {10'd113, 10'd832}) begin
      n_miss++;
      $display("FAIL rise_addr5: got %h want %h", data_at[5], {10'd113, 10'd832});
    end
    n_vec++;
    if (data_at[15] !== {10'd123, 10'd448}) begin
      n_miss++;
      $display("FAIL rise_addr15: got %h want %h", data_at[15], {10'd123, 10'd448});
    end
    n_vec++;
    if ({bus.done, bus.busy, bus.ad1oe, bus.ad2oe, bus.wr_en} !== 5'b10110) begin
      n_miss++;
      $display("FAIL rise_done: done busy oe1 oe2 wr %b want 10110", {bus.done, bus.busy, bus.ad1oe, bus.ad2oe, bus.wr_en});
    end
    n_vec++;
    if (bus.wr_addr !== 4'd15 || done_rise_cyc != cyc_last + 1) begin
      n_miss++;
      $display("FAIL rise_done_timing: addr %0d done_cyc %0d want 15 %0d", bus.wr_addr, done_rise_cyc, cyc_last + 1);
    end
    n_vec++;
    if (bus.otr1_cnt !== 2'd0 || bus.otr2_cnt !== 2'd0) begin
      n_miss++;
      $display("FAIL rise_otr: got %0d %0d want 0 0", bus.otr1_cnt, bus.otr2_cnt);
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_miss++;
      $display("FAIL rise_ack: done %b busy %b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_falling();
    int base_wr;
    int v;
    base_wr = total_wr;
    bus.trig_rising = 1'b0;
    bus.trig_level  = 10'd500;
    bus.ad_data1    = 10'd900;
    bus.ad_data2    = 10'd123;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    for (int j = 0; j < 30; j++) begin
      v = 900 - 100 * j;
      if (v < 100) v = 100;
      bus.ad_data1 = 10'(v);
      bus.ad_data2 = 10'(1023 - v);
      step();
    end
    n_vec++;
    if (total_wr - base_wr != 16 || bus.done !== 1'b1) begin
      n_miss++;
      $display("FAIL fall_count: writes %0d done %b want 16 1", total_wr - base_wr, bus.done);
    end
    n_vec++;
    if (data_at[0] !== {10'd523, 10'd500}) begin
      n_miss++;
      $display("FAIL fall_addr0: got %h want %h", data_at[0], {10'd523, 10'd500});
    end
    n_vec++;
    if (data_at[1] !== {10'd623, 10'd400}) begin
      n_miss++;
      $display("FAIL fall_addr1: got %h want %h", data_at[1], {10'd623, 10'd400});
    end
    n_vec++;
    if (data_at[10] !== {10'd923, 10'd100}) begin
      n_miss++;
      $display("FAIL fall_addr10: got %h want %h", data_at[10], {10'd923, 10'd100});
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    bus.trig_rising = 1'b1;
    bus.trig_level  = 10'd512;
  endtask

  task automatic test_force();
    int base_wr;
    int base_seq;
    int force_cyc;
    base_wr  = total_wr;
    base_seq = seq_err;
    bus.ad_data1 = '0;
    bus.ad_data2 = 10'd77;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.force_trig = (i == 2);
      step();
    end
    bus.force_trig = 1'b0;
    n_vec++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_miss++;
      $display("FAIL force_pre: wr_en %b busy %b want 0 1", bus.wr_en, bus.busy);
    end
    bus.force_trig = 1'b1;
    force_cyc = cyc;
    step();
    bus.force_trig = 1'b0;
    n_vec++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd0 || cyc != force_cyc + 1) begin
      n_miss++;
      $display("FAIL force_start: wr_en %b addr %0d want 1 0", bus.wr_en, bus.wr_addr);
    end
    for (int i = 0; i < 25; i++) step();
    n_vec++;
    if (total_wr - base_wr != 16 || seq_err != base_seq || bus.done !== 1'b1) begin
      n_miss++;
      $display("FAIL force_count: writes %0d seq_err %0d done %b want 16 0 1", total_wr - base_wr, seq_err - base_seq, bus.done);
    end
    n_vec++;
    if (data_at[3] !== {10'd77, 10'd0}) begin
      n_miss++;
      $display("FAIL force_data: got %h want %h", data_at[3], {10'd77, 10'd0});
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic test_otr();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.OTR2       = 1'b1;
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.OTR1 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.OTR1 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    bus.OTR2 = 1'b0;
    n_vec++;
    if (bus.otr1_cnt !== 2'd3 || bus.otr2_cnt !== 2'd3 || bus.done !== 1'b1) begin
      n_miss++;
      $display("FAIL otr_sat: got %0d %0d done %b want 3 3 1", bus.otr1_cnt, bus.otr2_cnt, bus.done);
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    step();
    n_vec++;
    if (bus.otr1_cnt !== 2'd3 || bus.otr2_cnt !== 2'd3) begin
      n_miss++;
      $display("FAIL otr_hold: got %0d %0d want 3 3", bus.otr1_cnt, bus.otr2_cnt);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_vec++;
    if (bus.otr1_cnt !== 2'd0 || bus.otr2_cnt !== 2'd0) begin
      n_miss++;
      $display("FAIL otr_clear: got %0d %0d want 0 0", bus.otr1_cnt, bus.otr2_cnt);
    end
    for (int i = 0; i < 10; i++) step();
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    for (int i = 0; i < 25; i++) step();
    n_vec++;
    if (bus.otr1_cnt !== 2'd0 || bus.otr2_cnt !== 2'd0 || bus.done !== 1'b1) begin
      n_miss++;
      $display("FAIL otr_quiet: got %0d %0d done %b want 0 0 1", bus.otr1_cnt, bus.otr2_cnt, bus.done);
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic test_ignore();
    int base_wr;
    base_wr = total_wr;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_miss++;
      $display("FAIL ign_ack_wait: busy %b done %b want 1 0", bus.busy, bus.done);
    end
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 25; i++) step();
    n_vec++;
    if (total_wr - base_wr != 16 || bus.done !== 1'b1) begin
      n_miss++;
      $display("FAIL ign_start_cap: writes %0d done %b want 16 1", total_wr - base_wr, bus.done);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_vec++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_miss++;
      $display("FAIL ign_start_done: done %b busy %b want 1 0", bus.done, bus.busy);
    end
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    step();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_miss++;
      $display("FAIL ign_start_ack: done %b busy %b want 0 0", bus.done, bus.busy);
    end
    for (int i = 0; i < 3; i++) step();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.ad1oe !== 1'b1) begin
      n_miss++;
      $display("FAIL ign_stay_idle: busy %b oe %b want 0 1", bus.busy, bus.ad1oe);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_miss++;
      $display("FAIL ign_restart: busy %b want 1", bus.busy);
    end
    for (int i = 0; i < 10; i++) step();
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    for (int i = 0; i < 25; i++) step();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic test_rst_mid();
    int base_wr;
    int base_seq;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    for (int i = 0; i < 20 && bus.wr_addr != 4'd7; i++) step();
    n_vec++;
    if (bus.wr_addr !== 4'd7 || bus.wr_en !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_reach_w7: addr %0d wr_en %b want 7 1", bus.wr_addr, bus.wr_en);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.wr_en, bus.busy, bus.done, bus.ad1oe, bus.ad2oe} !== 5'b00011 || bus.wr_addr !== 4'd0) begin
      n_miss++;
      $display("FAIL rst_async: wr busy done oe1 oe2 %b addr %0d want 00011 0",
               {bus.wr_en, bus.busy, bus.done, bus.ad1oe, bus.ad2oe}, bus.wr_addr);
    end
    step();
    step();
    rst = 1'b0;
    step();
    base_wr  = total_wr;
    base_seq = seq_err;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    for (int i = 0; i < 25; i++) step();
    n_vec++;
    if (total_wr - base_wr != 16 || seq_err != base_seq || bus.done !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_recover: writes %0d seq_err %0d done %b want 16 0 1", total_wr - base_wr, seq_err - base_seq, bus.done);
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.force_trig  = 1'b0;
    bus.trig_level  = 10'd512;
    bus.trig_rising = 1'b1;
    bus.ack         = 1'b0;
    bus.ad_data1    = '0;
    bus.ad_data2    = '0;
    bus.OTR1        = 1'b0;
    bus.OTR2        = 1'b0;
    test_reset();
    test_rising();
    test_falling();
    test_force();
    test_otr();
    test_ignore();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
